// File: rtl/apb_device_info_generic.sv
// apb_device_info_generic
//   APB device information block: die serial number, IDCODE, USERCODE and
//   status. Sequences an external DNA-style serial shift port after a boot
//   delay and fetches IDCODE from an external config-port sequencer through a
//   level request / pulse acknowledge handshake guarded by a timeout. Both
//   fetches can be re-triggered by software through CONTROL.
//   Optional feature: define DEVINFO_SCRATCH_EN to add a 32-bit R/W SCRATCH
//   register at 0x20; without it 0x20 is unmapped.
module apb_device_info_generic #(
   parameter int SERIAL_WIDTH   = 57,
   parameter int BOOT_DELAY     = 1024,
   parameter int IDCODE_TIMEOUT = 4096
) (
   input  logic        pclk,
   input  logic        preset_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [7:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        dna_read,
   output logic        dna_shift,
   input  logic        dna_dout,
   output logic        idcode_req,
   input  logic        idcode_ack,
   input  logic [31:0] idcode_data,
   input  logic [31:0] usercode
);

   localparam int BOOT_W = $clog2(BOOT_DELAY + 1);
   localparam int CNT_W  = (SERIAL_WIDTH > 1) ? $clog2(SERIAL_WIDTH) : 1;
   localparam int TMR_W  = $clog2(IDCODE_TIMEOUT + 1);

   localparam logic [7:0] ADDR_STATUS   = 8'h00;
   localparam logic [7:0] ADDR_IDCODE   = 8'h04;
   localparam logic [7:0] ADDR_CONTROL  = 8'h08;
   localparam logic [7:0] ADDR_SERIAL3  = 8'h0C;
   localparam logic [7:0] ADDR_SERIAL2  = 8'h10;
   localparam logic [7:0] ADDR_SERIAL1  = 8'h14;
   localparam logic [7:0] ADDR_SERIAL0  = 8'h18;
   localparam logic [7:0] ADDR_USERCODE = 8'h1C;
`ifdef DEVINFO_SCRATCH_EN
   localparam logic [7:0] ADDR_SCRATCH  = 8'h20;
`endif

   typedef enum logic [1:0] {
      SER_BOOT  = 2'd0,
      SER_LOAD  = 2'd1,
      SER_SHIFT = 2'd2,
      SER_DONE  = 2'd3
   } ser_state_t;

   typedef enum logic [1:0] {
      ID_BOOT = 2'd0,
      ID_REQ  = 2'd1,
      ID_DONE = 2'd2
   } id_state_t;

   // boot delay
   logic [BOOT_W-1:0]       boot_cnt_r;
   logic                    boot_done_r;

   // APB decode
   logic                    access_s;
   logic                    ctrl_wr_s;
   logic                    rescan_s;
   logic                    rerequest_s;
   logic [31:0]             rd_data_s;
   logic                    rd_ok_s;
   logic                    wr_ok_s;
   logic [127:0]            serial_ext_s;

   // serial FSM
   ser_state_t              ser_state_r;
   ser_state_t              ser_state_nxt_s;
   logic [SERIAL_WIDTH-1:0] serial_r;
   logic [SERIAL_WIDTH-1:0] serial_nxt_s;
   logic [CNT_W-1:0]        ser_cnt_r;
   logic [CNT_W-1:0]        ser_cnt_nxt_s;
   logic                    serial_valid_r;
   logic                    serial_valid_nxt_s;
   logic                    dna_read_r;
   logic                    dna_shift_r;

   // IDCODE FSM
   id_state_t               id_state_r;
   id_state_t               id_state_nxt_s;
   logic [TMR_W-1:0]        id_timer_r;
   logic [TMR_W-1:0]        id_timer_nxt_s;
   logic [31:0]             idcode_r;
   logic [31:0]             idcode_nxt_s;
   logic                    id_valid_r;
   logic                    id_valid_nxt_s;
   logic                    id_err_r;
   logic                    id_err_nxt_s;
   logic                    idcode_req_r;

   logic                    serial_busy_s;
   logic                    idcode_busy_s;

`ifdef DEVINFO_SCRATCH_EN
   logic [31:0]             scratch_r;
`endif

   // Upper write-data bits are only meaningful for SCRATCH.
   logic                    unused_wdata_s;
   assign unused_wdata_s = &{1'b0, pwdata[31:2]};

   // ------------------------------------------------------------------
   // Boot delay: no primitive is touched until the counter expires.
   // ------------------------------------------------------------------

   // Count BOOT_DELAY cycles after reset release, then hold boot_done.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         boot_cnt_r  <= '0;
         boot_done_r <= 1'b0;
      end else if (!boot_done_r) begin
         if (boot_cnt_r == BOOT_W'(BOOT_DELAY - 1)) begin
            boot_done_r <= 1'b1;
         end else begin
            boot_cnt_r <= boot_cnt_r + BOOT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // APB decode: zero wait states, CONTROL bits act on the access phase.
   // ------------------------------------------------------------------
   assign access_s     = psel & penable;
   assign ctrl_wr_s    = access_s & pwrite & (paddr == ADDR_CONTROL);
   assign rescan_s     = ctrl_wr_s & pwdata[0];
   assign rerequest_s  = ctrl_wr_s & pwdata[1];
   assign serial_ext_s = 128'(serial_r);

   assign serial_busy_s = (ser_state_r == SER_LOAD) || (ser_state_r == SER_SHIFT);
   assign idcode_busy_s = (id_state_r == ID_REQ);

   // Read mux plus per-address read/write legality.
   always_comb begin
      rd_data_s = 32'h0;
      rd_ok_s   = 1'b1;
      wr_ok_s   = 1'b0;
      case (paddr)
         ADDR_STATUS:   rd_data_s = {27'h0, id_err_r, idcode_busy_s, serial_busy_s,
                                     serial_valid_r, id_valid_r};
         ADDR_IDCODE:   rd_data_s = idcode_r;
         ADDR_CONTROL:  begin
            rd_data_s = 32'h0;
            wr_ok_s   = 1'b1;
         end
         ADDR_SERIAL3:  rd_data_s = serial_ext_s[127:96];
         ADDR_SERIAL2:  rd_data_s = serial_ext_s[95:64];
         ADDR_SERIAL1:  rd_data_s = serial_ext_s[63:32];
         ADDR_SERIAL0:  rd_data_s = serial_ext_s[31:0];
         ADDR_USERCODE: rd_data_s = usercode;
`ifdef DEVINFO_SCRATCH_EN
         ADDR_SCRATCH:  begin
            rd_data_s = scratch_r;
            wr_ok_s   = 1'b1;
         end
`endif
         default:       rd_ok_s = 1'b0;
      endcase
   end

   assign pready  = access_s;
   assign prdata  = (access_s && !pwrite) ? rd_data_s : 32'h0;
   assign pslverr = access_s & (pwrite ? ~wr_ok_s : ~rd_ok_s);

`ifdef DEVINFO_SCRATCH_EN
   // Software scratch register, written on the access phase.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         scratch_r <= 32'h0;
      end else if (access_s && pwrite && (paddr == ADDR_SCRATCH)) begin
         scratch_r <= pwdata;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Serial FSM: one READ pulse, then exactly SERIAL_WIDTH shift samples.
   // The port presents its MSB right after READ, so every SHIFT cycle both
   // samples dna_dout and advances the external register.
   // ------------------------------------------------------------------

   // Serial next-state and datapath.
   always_comb begin
      ser_state_nxt_s    = ser_state_r;
      serial_nxt_s       = serial_r;
      ser_cnt_nxt_s      = ser_cnt_r;
      serial_valid_nxt_s = serial_valid_r;
      case (ser_state_r)
         SER_BOOT: begin
            if (boot_done_r) begin
               ser_state_nxt_s = SER_LOAD;
            end else begin
               ser_state_nxt_s = SER_BOOT;
            end
         end
         SER_LOAD: begin
            ser_state_nxt_s = SER_SHIFT;
            ser_cnt_nxt_s   = '0;
         end
         SER_SHIFT: begin
            serial_nxt_s = SERIAL_WIDTH'({serial_r, dna_dout});
            if (ser_cnt_r == CNT_W'(SERIAL_WIDTH - 1)) begin
               ser_state_nxt_s    = SER_DONE;
               serial_valid_nxt_s = 1'b1;
            end else begin
               ser_cnt_nxt_s = ser_cnt_r + CNT_W'(1);
            end
         end
         SER_DONE: begin
            if (rescan_s) begin
               serial_nxt_s       = '0;
               serial_valid_nxt_s = 1'b0;
               ser_state_nxt_s    = SER_LOAD;
            end else begin
               ser_state_nxt_s = SER_DONE;
            end
         end
         default: ser_state_nxt_s = SER_BOOT;
      endcase
   end

   // Serial state, datapath and registered port controls.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         ser_state_r    <= SER_BOOT;
         serial_r       <= '0;
         ser_cnt_r      <= '0;
         serial_valid_r <= 1'b0;
         dna_read_r     <= 1'b0;
         dna_shift_r    <= 1'b0;
      end else begin
         ser_state_r    <= ser_state_nxt_s;
         serial_r       <= serial_nxt_s;
         ser_cnt_r      <= ser_cnt_nxt_s;
         serial_valid_r <= serial_valid_nxt_s;
         dna_read_r     <= (ser_state_nxt_s == SER_LOAD);
         dna_shift_r    <= (ser_state_nxt_s == SER_SHIFT);
      end
   end

   assign dna_read  = dna_read_r;
   assign dna_shift = dna_shift_r;

   // ------------------------------------------------------------------
   // IDCODE FSM: request held for at most IDCODE_TIMEOUT cycles; an ack
   // arriving on the final cycle still counts as success.
   // ------------------------------------------------------------------

   // IDCODE next-state and datapath.
   always_comb begin
      id_state_nxt_s = id_state_r;
      id_timer_nxt_s = id_timer_r;
      idcode_nxt_s   = idcode_r;
      id_valid_nxt_s = id_valid_r;
      id_err_nxt_s   = id_err_r;
      case (id_state_r)
         ID_BOOT: begin
            if (boot_done_r) begin
               id_state_nxt_s = ID_REQ;
               id_timer_nxt_s = '0;
            end else begin
               id_state_nxt_s = ID_BOOT;
            end
         end
         ID_REQ: begin
            if (idcode_ack) begin
               idcode_nxt_s   = idcode_data;
               id_valid_nxt_s = 1'b1;
               id_err_nxt_s   = 1'b0;
               id_state_nxt_s = ID_DONE;
            end else if (id_timer_r == TMR_W'(IDCODE_TIMEOUT - 1)) begin
               id_valid_nxt_s = 1'b0;
               id_err_nxt_s   = 1'b1;
               id_state_nxt_s = ID_DONE;
            end else begin
               id_timer_nxt_s = id_timer_r + TMR_W'(1);
            end
         end
         ID_DONE: begin
            if (rerequest_s) begin
               id_valid_nxt_s = 1'b0;
               id_err_nxt_s   = 1'b0;
               id_timer_nxt_s = '0;
               id_state_nxt_s = ID_REQ;
            end else begin
               id_state_nxt_s = ID_DONE;
            end
         end
         default: id_state_nxt_s = ID_BOOT;
      endcase
   end

   // IDCODE state, captured value, flags and registered request.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         id_state_r   <= ID_BOOT;
         id_timer_r   <= '0;
         idcode_r     <= 32'h0;
         id_valid_r   <= 1'b0;
         id_err_r     <= 1'b0;
         idcode_req_r <= 1'b0;
      end else begin
         id_state_r   <= id_state_nxt_s;
         id_timer_r   <= id_timer_nxt_s;
         idcode_r     <= idcode_nxt_s;
         id_valid_r   <= id_valid_nxt_s;
         id_err_r     <= id_err_nxt_s;
         idcode_req_r <= (id_state_nxt_s == ID_REQ);
      end
   end

   assign idcode_req = idcode_req_r;

endmodule

// File: tb/tb_apb_device_info_generic.sv
// tb_apb_device_info_generic
//   Two instances: A (57-bit serial, IDCODE sequencer modelled by the bench)
//   and B (96-bit serial, IDCODE ack tied low). Expected values come from the
//   DNA contents, the acked IDCODE values and the status bit definitions.
//   Honours DEVINFO_SCRATCH_EN for the 0x20 expectations.
module tb_apb_device_info_generic;

   localparam int BOOT = 40;
   localparam int TMO  = 64;
   localparam int WA   = 57;
   localparam int WB   = 96;

   logic          pclk = 1'b0;
   logic          preset_n;
   logic          psel_a, psel_b, penable, pwrite;
   logic [7:0]    paddr;
   logic [31:0]   pwdata;
   logic [31:0]   prdata_a, prdata_b;
   logic          pready_a, pready_b, pslverr_a, pslverr_b;
   logic          dna_read_a, dna_shift_a, dna_dout_a;
   logic          dna_read_b, dna_shift_b, dna_dout_b;
   logic          idcode_req_a, idcode_ack_a, idcode_req_b;
   logic [31:0]   idcode_data_a, usercode_a, usercode_b;

   int            checks = 0;
   int            errors = 0;
   int            rd_pulses_a = 0;
   int            shift_cyc_a = 0;
   int            req_cyc_a = 0;

   logic [WA-1:0] dna_val_a;
   logic [WA-1:0] dna_sr_a = '0;
   logic [WB-1:0] dna_val_b;
   logic [WB-1:0] dna_sr_b = '0;

   always #5 pclk = ~pclk;

   apb_device_info_generic #(.SERIAL_WIDTH(WA), .BOOT_DELAY(BOOT), .IDCODE_TIMEOUT(TMO)) dut_a (
      .pclk(pclk), .preset_n(preset_n), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a),
      .dna_read(dna_read_a), .dna_shift(dna_shift_a), .dna_dout(dna_dout_a),
      .idcode_req(idcode_req_a), .idcode_ack(idcode_ack_a), .idcode_data(idcode_data_a),
      .usercode(usercode_a));

   apb_device_info_generic #(.SERIAL_WIDTH(WB), .BOOT_DELAY(BOOT), .IDCODE_TIMEOUT(TMO)) dut_b (
      .pclk(pclk), .preset_n(preset_n), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b),
      .dna_read(dna_read_b), .dna_shift(dna_shift_b), .dna_dout(dna_dout_b),
      .idcode_req(idcode_req_b), .idcode_ack(1'b0), .idcode_data(32'h0),
      .usercode(usercode_b));

   // External DNA ports: READ loads the die value, SHIFT moves it towards the MSB output.
   always @(posedge pclk) begin
      if (dna_read_a) dna_sr_a <= dna_val_a;
      else if (dna_shift_a) dna_sr_a <= {dna_sr_a[WA-2:0], 1'b0};
      if (dna_read_b) dna_sr_b <= dna_val_b;
      else if (dna_shift_b) dna_sr_b <= {dna_sr_b[WB-2:0], 1'b0};
   end
   assign dna_dout_a = dna_sr_a[WA-1];
   assign dna_dout_b = dna_sr_b[WB-1];

   // Activity monitors on instance A.
   always @(posedge pclk) begin
      rd_pulses_a <= rd_pulses_a + (dna_read_a ? 1 : 0);
      shift_cyc_a <= shift_cyc_a + (dna_shift_a ? 1 : 0);
      req_cyc_a   <= req_cyc_a + (idcode_req_a ? 1 : 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_exp(input bit idv, input bit sv, input bit sb,
                                              input bit ib, input bit ie);
      return 32'(idv) + 32'(sv) * 2 + 32'(sb) * 4 + 32'(ib) * 8 + 32'(ie) * 16;
   endfunction

   // Word idx 0..3 of the 128-bit serial view at 0x0C + 4*idx.
   function automatic logic [31:0] ser_word(input logic [127:0] v, input int idx);
      return 32'(v >> (32 * (3 - idx)));
   endfunction

   task automatic apb(input bit b_sel, input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err);
      @(negedge pclk);
      psel_a = !b_sel; psel_b = b_sel; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      rd  = b_sel ? prdata_b : prdata_a;
      err = b_sel ? pslverr_b : pslverr_a;
      check("pready", 32'(b_sel ? pready_b : pready_a), 32'h1);
      @(negedge pclk);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_chk(input bit b_sel, input logic [7:0] a, input logic [31:0] exp,
                         input logic exp_err, input string tag);
      logic [31:0] r; logic e;
      apb(b_sel, 1'b0, a, 32'h0, r, e);
      check({tag, "_data"}, r, exp);
      check({tag, "_slverr"}, 32'(e), 32'(exp_err));
   endtask

   task automatic wr_chk(input bit b_sel, input logic [7:0] a, input logic [31:0] d,
                         input logic exp_err, input string tag);
      logic [31:0] r; logic e;
      apb(b_sel, 1'b1, a, d, r, e);
      check({tag, "_slverr"}, 32'(e), 32'(exp_err));
   endtask

   task automatic poll_bit(input bit b_sel, input int bitn, input string tag);
      logic [31:0] r; logic e; bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         apb(b_sel, 1'b0, 8'h00, 32'h0, r, e);
         seen = r[bitn];
      end
      check(tag, 32'(seen), 32'h1);
   endtask

   task automatic check_serial_a(input string tag);
      for (int k = 0; k < 4; k++)
         rd_chk(1'b0, 8'(8'h0C + 4 * k), ser_word(128'(dna_val_a), k), 1'b0, tag);
   endtask

   task automatic ack_pulse(input logic [31:0] d);
      idcode_ack_a = 1'b1; idcode_data_a = d;
      @(negedge pclk);
      idcode_ack_a = 1'b0; idcode_data_a = ~d;
   endtask

   initial begin
      logic [31:0] idv, idv2, idv3;
      int snap_rd, snap_sh, snap_req, dly;
      bit seen;

      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 32'h0; idcode_ack_a = 1'b0; idcode_data_a = 32'h0;
      usercode_a = $urandom; usercode_b = $urandom;
      dna_val_a = 57'h0adbeef_c0def00d;
      dna_val_b = '1;
      preset_n = 1'b0;

      // Reset state
      repeat (3) @(negedge pclk);
      #1;
      check("rst_dna_read", 32'(dna_read_a | dna_read_b), 32'h0);
      check("rst_dna_shift", 32'(dna_shift_a | dna_shift_b), 32'h0);
      check("rst_idcode_req", 32'(idcode_req_a | idcode_req_b), 32'h0);
      check("rst_prdata", prdata_a | prdata_b, 32'h0);
      check("rst_pslverr", 32'(pslverr_a | pslverr_b), 32'h0);
      @(negedge pclk);
      preset_n = 1'b1;

      rd_chk(1'b0, 8'h00, 32'h0, 1'b0, "status_boot");
      rd_chk(1'b0, 8'h1C, usercode_a, 1'b0, "usercode_a");
      rd_chk(1'b1, 8'h1C, usercode_b, 1'b0, "usercode_b");
      rd_chk(1'b0, 8'h08, 32'h0, 1'b0, "control_read");

      // IDCODE acked 10 cycles after the request
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge pclk);
         seen = idcode_req_a;
      end
      check("req_rise", 32'(seen), 32'h1);
      idv = $urandom;
      repeat (10) @(negedge pclk);
      ack_pulse(idv);
      check("req_drop_after_ack", 32'(idcode_req_a), 32'h0);

      // Rescan request during SHIFT is ignored
      check("in_shift", 32'(dna_shift_a), 32'h1);
      wr_chk(1'b0, 8'h08, 32'h1, 1'b0, "ctrl_rescan_busy");
      poll_bit(1'b0, 1, "serial_valid_1");
      check("read_pulses", 32'(rd_pulses_a), 32'd1);
      check("shift_cycles", 32'(shift_cyc_a), 32'(WA));
      rd_chk(1'b0, 8'h00, status_exp(1, 1, 0, 0, 0), 1'b0, "status_both_done");
      rd_chk(1'b0, 8'h04, idv, 1'b0, "idcode_1");
      check_serial_a("serial_directed");

      // Rescan from DONE: same value again
      snap_rd = rd_pulses_a; snap_sh = shift_cyc_a;
      wr_chk(1'b0, 8'h08, 32'h1, 1'b0, "ctrl_rescan");
      rd_chk(1'b0, 8'h00, status_exp(1, 0, 1, 0, 0), 1'b0, "status_rescan_busy");
      poll_bit(1'b0, 1, "serial_valid_2");
      check("rescan_pulses", 32'(rd_pulses_a - snap_rd), 32'd1);
      check("rescan_shifts", 32'(shift_cyc_a - snap_sh), 32'(WA));
      check_serial_a("serial_rescan");

      // Rescan with a random die value
      dna_val_a = WA'({$urandom, $urandom});
      wr_chk(1'b0, 8'h08, 32'h1, 1'b0, "ctrl_rescan_rand");
      poll_bit(1'b0, 1, "serial_valid_3");
      check_serial_a("serial_random");

      // Re-request without ack: timeout after exactly TMO request cycles
      snap_req = req_cyc_a;
      wr_chk(1'b0, 8'h08, 32'h2, 1'b0, "ctrl_rereq_tmo");
      rd_chk(1'b0, 8'h00, status_exp(0, 1, 0, 1, 0), 1'b0, "status_req_busy");
      poll_bit(1'b0, 4, "idcode_err");
      check("req_cycles_tmo", 32'(req_cyc_a - snap_req), 32'(TMO));
      rd_chk(1'b0, 8'h00, status_exp(0, 1, 0, 0, 1), 1'b0, "status_tmo");

      // Ack on the final timeout cycle wins
      snap_req = req_cyc_a;
      idv2 = $urandom;
      wr_chk(1'b0, 8'h08, 32'h2, 1'b0, "ctrl_rereq_edge");
      repeat (TMO - 1) @(negedge pclk);
      ack_pulse(idv2);
      check("req_cycles_edge", 32'(req_cyc_a - snap_req), 32'(TMO));
      rd_chk(1'b0, 8'h00, status_exp(1, 1, 0, 0, 0), 1'b0, "status_ack_wins");
      rd_chk(1'b0, 8'h04, idv2, 1'b0, "idcode_2");

      // Random ack latency
      snap_req = req_cyc_a;
      idv3 = $urandom;
      dly = int'($urandom_range(1, 50));
      wr_chk(1'b0, 8'h08, 32'h2, 1'b0, "ctrl_rereq_rand");
      repeat (dly) @(negedge pclk);
      ack_pulse(idv3);
      check("req_cycles_rand", 32'(req_cyc_a - snap_req), 32'(dly + 1));
      rd_chk(1'b0, 8'h00, status_exp(1, 1, 0, 0, 0), 1'b0, "status_rand_ack");
      rd_chk(1'b0, 8'h04, idv3, 1'b0, "idcode_3");

      // Ack outside REQ is ignored
      ack_pulse(~idv3);
      rd_chk(1'b0, 8'h04, idv3, 1'b0, "idcode_stray_ack");

      // Unmapped / read-only accesses
      rd_chk(1'b0, 8'h24, 32'h0, 1'b1, "rd_0x24");
      wr_chk(1'b0, 8'h04, 32'h12345678, 1'b1, "wr_idcode");
      wr_chk(1'b0, 8'h00, 32'h3, 1'b1, "wr_status");
      wr_chk(1'b0, 8'h1C, 32'h1, 1'b1, "wr_usercode");
      rd_chk(1'b0, 8'h04, idv3, 1'b0, "idcode_after_bad_wr");
      rd_chk(1'b0, 8'h00, status_exp(1, 1, 0, 0, 0), 1'b0, "status_after_bad_wr");
`ifdef DEVINFO_SCRATCH_EN
      rd_chk(1'b0, 8'h20, 32'h0, 1'b0, "scratch_reset");
      wr_chk(1'b0, 8'h20, 32'hdeadbeef, 1'b0, "scratch_wr");
      rd_chk(1'b0, 8'h20, 32'hdeadbeef, 1'b0, "scratch_rd");
`else
      wr_chk(1'b0, 8'h20, 32'hdeadbeef, 1'b1, "scratch_wr_unmapped");
      rd_chk(1'b0, 8'h20, 32'h0, 1'b1, "scratch_rd_unmapped");
`endif

      // Instance B: 96-bit all-ones serial, IDCODE times out
      poll_bit(1'b1, 1, "b_serial_valid");
      rd_chk(1'b1, 8'h00, status_exp(0, 1, 0, 0, 1), 1'b0, "b_status");
      for (int k = 0; k < 4; k++)
         rd_chk(1'b1, 8'(8'h0C + 4 * k), ser_word(128'(dna_val_b), k), 1'b0, "b_serial");

      // Reset mid-operation drops the port controls at once
      wr_chk(1'b0, 8'h08, 32'h3, 1'b0, "ctrl_both");
      repeat (5) @(negedge pclk);
      check("mid_shift_active", 32'(dna_shift_a), 32'h1);
      check("mid_req_active", 32'(idcode_req_a), 32'h1);
      #2;
      preset_n = 1'b0;
      #1;
      check("async_shift_drop", 32'(dna_shift_a), 32'h0);
      check("async_req_drop", 32'(idcode_req_a), 32'h0);
      check("async_read_low", 32'(dna_read_a), 32'h0);
      @(negedge pclk);
      preset_n = 1'b1;
      rd_chk(1'b0, 8'h00, 32'h0, 1'b0, "status_after_reset");
      rd_chk(1'b0, 8'h18, 32'h0, 1'b0, "serial_after_reset");
      rd_chk(1'b0, 8'h04, 32'h0, 1'b0, "idcode_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
